// File: rtl/uart_frame_rx.sv
// Frame receiver: SOF, fixed-length payload, XOR checksum; accepted frames are
// committed to a holding register and offered downstream via valid/ready.
module uart_frame_rx #(
    parameter int         PAYLOAD_BYTES  = 32,
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 17360
) (
    input  logic                       CLOCK_50,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       err_checksum,
    output logic                       err_timeout,
    output logic                       err_overrun,
    output logic [15:0]                frame_count,
    output logic [1:0]                 fsm_state
);

    localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_t;

    state_t                     state, state_next;
    logic [IW-1:0]              idx;
    logic [7:0]                 chk;
    logic [TW-1:0]              timer;
    logic [8*PAYLOAD_BYTES-1:0] staging;

    logic start_frame, store_byte, check_byte, sum_ok;
    logic commit, overrun, bad_sum, timed_out;

    always_ff @(posedge CLOCK_50) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_frame) state_next = PAYLOAD;
            PAYLOAD: begin
                if (store_byte && idx == IW'(PAYLOAD_BYTES - 1)) state_next = CHECK;
                else if (timed_out)                               state_next = IDLE;
            end
            CHECK:   if (check_byte || timed_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake: a frame transfers on a cycle with frame_valid && frame_ready;
    // frame_data holds while frame_valid is high and only a commit replaces it.
    always_comb begin
        start_frame = (state == IDLE) && rx_valid && (rx_data == SOF);
        store_byte  = (state == PAYLOAD) && rx_valid;
        check_byte  = (state == CHECK) && rx_valid;
        sum_ok      = (rx_data == chk);
        commit      = check_byte && sum_ok && (!frame_valid || frame_ready);
        overrun     = check_byte && sum_ok && frame_valid && !frame_ready;
        bad_sum     = check_byte && !sum_ok;
        timed_out   = (state != IDLE) && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
        fsm_state   = state;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            idx          <= '0;
            chk          <= '0;
            timer        <= '0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            frame_count  <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (start_frame) begin
                idx <= '0;
                chk <= '0;
            end else if (store_byte) begin
                staging[int'(idx)*8 +: 8] <= rx_data;
                chk                       <= chk ^ rx_data;
                idx                       <= idx + 1'b1;
            end

            // Timer only runs on silent cycles inside a frame.
            if (state == IDLE || rx_valid || timed_out) timer <= '0;
            else                                        timer <= timer + 1'b1;

            if (commit) begin
                frame_data  <= staging;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end

            err_checksum <= bad_sum;
            err_timeout  <= timed_out;
            err_overrun  <= overrun;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus a commit
// scoreboard keyed on frame_count increments.
module tb_uart_frame_rx;

    localparam int         PB   = 32;
    localparam logic [7:0] SOF  = 8'hA5;
    localparam int         TOUT = 17360;

    logic            CLOCK_50 = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic [8*PB-1:0] frame_data;
    logic            frame_valid;
    logic            frame_ready = 1'b0;
    logic            err_checksum, err_timeout, err_overrun;
    logic [15:0]     frame_count;
    logic [1:0]      fsm_state;

    uart_frame_rx #(.PAYLOAD_BYTES(PB), .SOF(SOF), .TIMEOUT_CYCLES(TOUT)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .frame_count (frame_count),
        .fsm_state   (fsm_state)
    );

    // clock / watchdog
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // scoreboard
    logic [8*PB-1:0] exp_q[$];
    logic [15:0]     prev_count = 16'd0;
    logic [2:0]      prev_err = 3'b000;
    int              n_chk = 0, n_to = 0, n_ov = 0;
    logic [15:0]     exp_count = 16'd0;

    always @(negedge CLOCK_50) begin
        logic [2:0]      errs;
        logic [8*PB-1:0] exp;
        errs = {err_checksum, err_timeout, err_overrun};
        if (!rst) begin
            if (err_checksum) n_chk++;
            if (err_timeout)  n_to++;
            if (err_overrun)  n_ov++;
            if (errs != 3'b000) check_eq("err_onehot", 256'($countones(errs)), 256'd1);
            if (prev_err != 3'b000) check_eq("err_width", 256'(errs & prev_err), 256'd0);
            if (frame_count != prev_count) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_commit", 256'(frame_count), 256'(prev_count));
                end else begin
                    exp = exp_q.pop_front();
                    check_eq("sb_data", frame_data, exp);
                    check_eq("sb_count", 256'(frame_count), 256'(prev_count + 16'd1));
                    check_eq("sb_valid", 256'(frame_valid), 256'd1);
                end
            end
        end
        prev_err   = rst ? 3'b000 : errs;
        prev_count = frame_count;
    end

    // driver tasks (called at posedge+1)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [8*PB-1:0] p, input logic [7:0] c,
                              input bit ready_on_chk, input int max_gap);
        send_byte(SOF);
        for (int k = 0; k < PB; k++) begin
            idle($urandom_range(max_gap, 0));
            send_byte(p[8*k +: 8]);
        end
        idle($urandom_range(max_gap, 0));
        if (ready_on_chk) frame_ready = 1'b1;
        send_byte(c);
        frame_ready = 1'b0;
    endtask

    task automatic push_good(input logic [8*PB-1:0] p);
        exp_q.push_back(p);
        exp_count = exp_count + 16'd1;
    endtask

    task automatic consume();
        frame_ready = 1'b1;
        idle(1);
        frame_ready = 1'b0;
        check_eq("consume_valid_low", 256'(frame_valid), 256'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        idle(1);
        check_eq({tag, "_valid"}, 256'(frame_valid), 256'd0);
        check_eq({tag, "_data"},  frame_data, 256'd0);
        check_eq({tag, "_count"}, 256'(frame_count), 256'd0);
        check_eq({tag, "_errs"},  256'({err_checksum, err_timeout, err_overrun}), 256'd0);
        check_eq({tag, "_state"}, 256'(fsm_state), 256'd0);
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        exp_count = 16'd0;
    endtask

    function automatic logic [8*PB-1:0] seq_payload(input logic [7:0] start);
        logic [8*PB-1:0] p;
        for (int k = 0; k < PB; k++) p[8*k +: 8] = start + 8'(k);
        return p;
    endfunction

    function automatic logic [7:0] xor_bytes(input logic [8*PB-1:0] p);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < PB; k++) x ^= p[8*k +: 8];
        return x;
    endfunction

    function automatic logic [8*PB-1:0] rand_payload();
        logic [8*PB-1:0] p;
        for (int k = 0; k < PB; k++) p[8*k +: 8] = 8'($urandom_range(255, 0));
        return p;
    endfunction

    // main stimulus
    initial begin
        logic [8*PB-1:0] pa, pb, pc;
        int              n;
        idle(1);
        apply_reset("reset");

        // good frame 01..20, checksum 0x20
        pa = seq_payload(8'h01);
        push_good(pa);
        send_frame(pa, 8'h20, 1'b0, 2);
        check_eq("good_fv_latency", 256'(frame_valid), 256'd1);
        check_eq("good_byte0",  256'(frame_data[7:0]), 256'h01);
        check_eq("good_byte31", 256'(frame_data[255:248]), 256'h20);
        check_eq("good_count",  256'(frame_count), 256'd1);
        check_eq("good_no_err", 256'({err_checksum, err_timeout, err_overrun}), 256'd0);
        consume();

        // bad checksum, then a good frame
        send_frame(pa, 8'h21, 1'b0, 1);
        check_eq("badsum_pulse", 256'(err_checksum), 256'd1);
        check_eq("badsum_valid", 256'(frame_valid), 256'd0);
        check_eq("badsum_count", 256'(frame_count), 256'(exp_count));
        idle(1);
        check_eq("badsum_pulse_end", 256'(err_checksum), 256'd0);
        pb = seq_payload(8'h40);
        push_good(pb);
        send_frame(pb, xor_bytes(pb), 1'b0, 1);
        check_eq("after_bad_valid", 256'(frame_valid), 256'd1);
        consume();

        // timeout after SOF + 10 bytes
        send_byte(SOF);
        for (int k = 0; k < 10; k++) send_byte(8'(k));
        n = 0;
        for (int c = 1; c <= TOUT + 20; c++) begin
            idle(1);
            if (err_timeout) begin
                n = c;
                break;
            end
        end
        check_eq("timeout_latency", 256'(n), 256'(TOUT));
        check_eq("timeout_idle", 256'(fsm_state), 256'd0);
        pc = rand_payload();
        push_good(pc);
        send_frame(pc, xor_bytes(pc), 1'b0, 2);
        check_eq("after_timeout_valid", 256'(frame_valid), 256'd1);
        consume();

        // overrun: holding register full, ready low
        pa = rand_payload();
        push_good(pa);
        send_frame(pa, xor_bytes(pa), 1'b0, 1);
        pb = rand_payload();
        send_frame(pb, xor_bytes(pb), 1'b0, 1);
        check_eq("overrun_pulse", 256'(err_overrun), 256'd1);
        check_eq("overrun_kept",  frame_data, pa);
        check_eq("overrun_count", 256'(frame_count), 256'(exp_count));
        // ready on the commit cycle: new frame replaces the held one
        pc = rand_payload();
        push_good(pc);
        send_frame(pc, xor_bytes(pc), 1'b1, 1);
        check_eq("replace_valid", 256'(frame_valid), 256'd1);
        check_eq("replace_data",  frame_data, pc);
        check_eq("replace_no_ov", 256'(err_overrun), 256'd0);
        consume();

        // leading junk and SOF inside the payload
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h37);
        pa = rand_payload();
        pa[8*5 +: 8] = SOF;
        push_good(pa);
        send_frame(pa, xor_bytes(pa), 1'b0, 1);
        check_eq("sof_in_payload_byte", 256'(frame_data[8*5 +: 8]), 256'(SOF));
        consume();

        // reset mid-payload, then a fresh frame
        send_byte(SOF);
        for (int k = 0; k < 15; k++) send_byte(8'($urandom_range(255, 0)));
        apply_reset("rst_mid");
        pb = rand_payload();
        push_good(pb);
        send_frame(pb, xor_bytes(pb), 1'b0, 1);
        check_eq("post_rst_count", 256'(frame_count), 256'd1);
        // reset while a frame is held
        apply_reset("rst_held");
        pc = rand_payload();
        push_good(pc);
        send_frame(pc, xor_bytes(pc), 1'b0, 1);
        check_eq("post_rst2_valid", 256'(frame_valid), 256'd1);
        consume();

        // random frames
        for (int i = 0; i < 4; i++) begin
            pa = rand_payload();
            push_good(pa);
            send_frame(pa, xor_bytes(pa), 1'b0, 3);
            idle($urandom_range(3, 0));
            consume();
        end

        idle(2);
        check_eq("sb_drained",   256'(exp_q.size()), 256'd0);
        check_eq("final_count",  256'(frame_count), 256'(exp_count));
        check_eq("total_badsum", 256'(n_chk), 256'd1);
        check_eq("total_timeout", 256'(n_to), 256'd1);
        check_eq("total_overrun", 256'(n_ov), 256'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
